// File: rtl/seq_mon_pkg.sv
// Shared definitions for the "1011" detector match monitor: FSM encoding and
// default widths/thresholds.
package seq_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    SATUR = 2'd2
  } mon_state_e;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_GAP_W     = 8;
  localparam int DEF_BURST_GAP = 3;
  localparam int DEF_BURST_N   = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and load-to-one, used for the match count
// and the inter-match gap count.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         load1,
  output logic [W-1:0] q,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V  = {W{1'b1}};
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};
  localparam logic [W-1:0] ONE_V  = W'(1);

  logic [W-1:0] q_r;

  // Count register: clear wins, then load-to-one, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= ZERO_V;
    end else if (clr) begin
      q_r <= ZERO_V;
    end else if (load1) begin
      q_r <= ONE_V;
    end else if (inc && (q_r != MAX_V)) begin
      q_r <= q_r + ONE_V;
    end else begin
      q_r <= q_r;
    end
  end

  assign q      = q_r;
  assign at_max = (q_r == MAX_V);

endmodule

// File: rtl/seq_match_monitor.sv
// Consumes the detector match pulse: counts matches, measures the gap between
// consecutive matches, tracks the minimum gap and flags bursts of close gaps.
module seq_match_monitor
  import seq_mon_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int GAP_W     = DEF_GAP_W,
  parameter int BURST_GAP = DEF_BURST_GAP,
  parameter int BURST_N   = DEF_BURST_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det,
  input  logic             clr,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic [GAP_W-1:0] last_gap,
  output logic             gap_valid,
  output logic [GAP_W-1:0] min_gap,
  output logic             burst
);

  localparam logic [CNT_W-1:0] CNT_NEAR_V  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [GAP_W-1:0] GAP_NEAR_V  = {{(GAP_W-1){1'b1}}, 1'b0};
  localparam logic [GAP_W-1:0] GAP_ONES_V  = {GAP_W{1'b1}};
  localparam logic [GAP_W-1:0] GAP_ZERO_V  = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] BURST_GAP_V = GAP_W'(BURST_GAP);
  localparam logic [8:0]       BURST_N_V   = 9'(BURST_N);

  mon_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] match_cnt_s;
  logic             match_at_max_s;
  logic [GAP_W-1:0] gap_cnt_s;
  logic             gap_at_max_s;
  logic             gap_inc_s, gap_load_s, report_s, enter_sat_s;
  logic [7:0]       run_cnt_r;
  logic [8:0]       run_inc_s;
  logic             close_s, fire_s;
  logic             cnt_sat_r, gap_valid_r, burst_r;
  logic [GAP_W-1:0] last_gap_r, min_gap_r;

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(det), .load1(1'b0),
    .q(match_cnt_s), .at_max(match_at_max_s)
  );

  sat_counter #(.W(GAP_W)) u_gap_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(gap_inc_s), .load1(gap_load_s),
    .q(gap_cnt_s), .at_max(gap_at_max_s)
  );

  // Next-state and gap-counter control; a match outside IDLE reports the running gap.
  always_comb begin
    state_nxt_s = state_r;
    gap_inc_s   = 1'b0;
    gap_load_s  = 1'b0;
    report_s    = 1'b0;
    enter_sat_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (det) begin
          gap_load_s  = 1'b1;
          state_nxt_s = TRACK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TRACK: begin
        if (det) begin
          report_s    = 1'b1;
          gap_load_s  = 1'b1;
          state_nxt_s = TRACK;
        end else if ((gap_cnt_s == GAP_NEAR_V) || gap_at_max_s) begin
          gap_inc_s   = 1'b1;
          enter_sat_s = 1'b1;
          state_nxt_s = SATUR;
        end else begin
          gap_inc_s   = 1'b1;
          state_nxt_s = TRACK;
        end
      end
      SATUR: begin
        if (det) begin
          report_s    = 1'b1;
          gap_load_s  = 1'b1;
          state_nxt_s = TRACK;
        end else begin
          state_nxt_s = SATUR;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  assign close_s   = (gap_cnt_s <= BURST_GAP_V);
  assign run_inc_s = {1'b0, run_cnt_r} + 9'd1;
  assign fire_s    = (run_inc_s == BURST_N_V);

  // State, gap report, minimum tracking and burst run counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      run_cnt_r   <= 8'd0;
      cnt_sat_r   <= 1'b0;
      last_gap_r  <= GAP_ZERO_V;
      gap_valid_r <= 1'b0;
      min_gap_r   <= GAP_ONES_V;
      burst_r     <= 1'b0;
    end else if (clr) begin
      state_r     <= IDLE;
      run_cnt_r   <= 8'd0;
      cnt_sat_r   <= 1'b0;
      last_gap_r  <= GAP_ZERO_V;
      gap_valid_r <= 1'b0;
      min_gap_r   <= GAP_ONES_V;
      burst_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_sat_r   <= match_at_max_s | (det & (match_cnt_s == CNT_NEAR_V));
      gap_valid_r <= report_s;
      burst_r     <= 1'b0;
      if (report_s) begin
        last_gap_r <= gap_cnt_s;
        if (gap_cnt_s < min_gap_r) begin
          min_gap_r <= gap_cnt_s;
        end
        if (close_s && fire_s) begin
          burst_r   <= 1'b1;
          run_cnt_r <= 8'd0;
        end else if (close_s) begin
          run_cnt_r <= run_inc_s[7:0];
        end else begin
          run_cnt_r <= 8'd0;
        end
      end else if (enter_sat_s) begin
        run_cnt_r <= 8'd0;
      end
    end
  end

  assign match_cnt = match_cnt_s;
  assign cnt_sat   = cnt_sat_r;
  assign last_gap  = last_gap_r;
  assign gap_valid = gap_valid_r;
  assign min_gap   = min_gap_r;
  assign burst     = burst_r;

endmodule

// File: tb/tb_seq_match_monitor.sv
// Directed bench for seq_match_monitor (CNT_W=4): a timing-based reference
// model pushes expected outputs per step into a queue, popped after each edge.
module tb_seq_match_monitor;

  logic       clk, rst, det, clr;
  logic [3:0] match_cnt;
  logic       cnt_sat, gap_valid, burst;
  logic [7:0] last_gap, min_gap;

  typedef struct {
    logic [3:0] cnt;
    logic       sat;
    logic [7:0] lg;
    logic       gv;
    logic [7:0] mg;
    logic       bu;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int m_cnt, m_lg, m_mg, m_run, m_last, e;
  bit m_sat, m_prev;

  seq_match_monitor #(.CNT_W(4), .GAP_W(8), .BURST_GAP(3), .BURST_N(4)) dut (
    .clk(clk), .rst(rst), .det(det), .clr(clr),
    .match_cnt(match_cnt), .cnt_sat(cnt_sat), .last_gap(last_gap),
    .gap_valid(gap_valid), .min_gap(min_gap), .burst(burst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sat = 1'b0; m_lg = 0; m_mg = 255; m_run = 0; m_prev = 1'b0;
  endtask

  // Model in terms of edge timestamps: gap = edge difference, capped at 255.
  task automatic predict(input logic d, input logic c, output exp_t x);
    int gap;
    e++;
    x.gv = 1'b0;
    x.bu = 1'b0;
    if (c) begin
      model_reset();
    end else if (d) begin
      if (m_prev) begin
        gap = e - m_last;
        if (gap > 255) gap = 255;
        m_lg = gap;
        x.gv = 1'b1;
        if (gap < m_mg) m_mg = gap;
        if (gap <= 3) begin
          if (m_run + 1 == 4) begin
            x.bu = 1'b1;
            m_run = 0;
          end else begin
            m_run = m_run + 1;
          end
        end else begin
          m_run = 0;
        end
      end
      m_prev = 1'b1;
      m_last = e;
      if (m_cnt < 15) m_cnt = m_cnt + 1;
      if (m_cnt == 15) m_sat = 1'b1;
    end
    x.cnt = 4'(m_cnt);
    x.sat = m_sat;
    x.lg  = 8'(m_lg);
    x.mg  = 8'(m_mg);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".match_cnt"}, 32'(match_cnt), 32'd0);
    chk({tag, ".cnt_sat"},   32'(cnt_sat),   32'd0);
    chk({tag, ".last_gap"},  32'(last_gap),  32'd0);
    chk({tag, ".gap_valid"}, 32'(gap_valid), 32'd0);
    chk({tag, ".min_gap"},   32'(min_gap),   32'hFF);
    chk({tag, ".burst"},     32'(burst),     32'd0);
  endtask

  task automatic step(input logic d, input logic c, input string tag);
    exp_t x, y;
    det = d;
    clr = c;
    predict(d, c, x);
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk({tag, ".match_cnt"}, 32'(match_cnt), 32'(y.cnt));
    chk({tag, ".cnt_sat"},   32'(cnt_sat),   32'(y.sat));
    chk({tag, ".last_gap"},  32'(last_gap),  32'(y.lg));
    chk({tag, ".gap_valid"}, 32'(gap_valid), 32'(y.gv));
    chk({tag, ".min_gap"},   32'(min_gap),   32'(y.mg));
    chk({tag, ".burst"},     32'(burst),     32'(y.bu));
  endtask

  initial begin
    rst = 1'b1; det = 1'b0; clr = 1'b0; e = 0; m_last = 0;
    model_reset();
    // T1 reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("t1_reset");
    rst = 1'b0;

    // T2 matches three edges apart
    step(1'b1, 1'b0, "t2");
    repeat (2) begin
      step(1'b0, 1'b0, "t2"); step(1'b0, 1'b0, "t2"); step(1'b1, 1'b0, "t2");
    end
    chk("t2_final_cnt", 32'(match_cnt), 32'd3);
    chk("t2_final_gap", 32'(last_gap), 32'd3);

    // T3 continuous det for six edges
    step(1'b0, 1'b1, "t3_clr");
    repeat (6) step(1'b1, 1'b0, "t3");
    chk("t3_final_min", 32'(min_gap), 32'd1);
    chk("t3_final_cnt", 32'(match_cnt), 32'd6);

    // close/non-close boundary: gap 4 breaks the run, gaps of 3 build a burst
    step(1'b0, 1'b1, "b_clr");
    repeat (4) step(1'b1, 1'b0, "b_run");
    repeat (3) step(1'b0, 1'b0, "b_idle");
    step(1'b1, 1'b0, "b_gap4");
    repeat (4) begin
      step(1'b0, 1'b0, "b_g3"); step(1'b0, 1'b0, "b_g3"); step(1'b1, 1'b0, "b_g3");
    end

    // T4 gap saturation
    step(1'b0, 1'b1, "t4_clr");
    step(1'b1, 1'b0, "t4");
    repeat (300) step(1'b0, 1'b0, "t4_idle");
    step(1'b1, 1'b0, "t4_sat");
    chk("t4_final_gap", 32'(last_gap), 32'hFF);
    chk("t4_final_min", 32'(min_gap), 32'hFF);

    // T5 match count saturation
    step(1'b0, 1'b1, "t5_clr");
    repeat (20) begin
      step(1'b1, 1'b0, "t5"); step(1'b0, 1'b0, "t5"); step(1'b0, 1'b0, "t5");
    end
    chk("t5_final_cnt", 32'(match_cnt), 32'hF);
    chk("t5_final_sat", 32'(cnt_sat), 32'd1);

    // T6 clr together with det discards the det
    step(1'b1, 1'b0, "t6a"); step(1'b1, 1'b0, "t6a");
    step(1'b1, 1'b1, "t6_clrdet");
    check_reset_vals("t6_clrdet_direct");
    step(1'b1, 1'b0, "t6_first");
    step(1'b1, 1'b0, "t6_second");

    // T6 asynchronous reset between edges
    step(1'b1, 1'b0, "t6b");
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("t6_async_rst");
    det = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, "t6_post_rst");
    step(1'b1, 1'b0, "t6_post_rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
